div_bcd_conv: RTL and testbench
===============================

# div_bcd_conv

Downstream result stage for the shift-subtract divider. Captures the divider's 8-bit quotient and 9-bit remainder when its done signal rises and converts both to 3-digit packed BCD with a sequential double-dabble, one iteration per clock. Holds the last valid result for the display/readout logic, with busy, valid and error/overrun status.

## Interface
Parameters:
- ITER, 8, binary width converted and number of dabble iterations; fixed at 8 for this design.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting (0) clears all state immediately; release is synchronous to clk.
- divEnd  input  1  divider done level from the divider FSM.
- quotient  input  8  divider quotient, valid while divEnd=1.
- remainder  input  9  divider P register. Bit 8 = sign; 1 means the result is invalid.
- qBcd  output  12  quotient BCD, hundreds[11:8] tens[7:4] units[3:0].
- rBcd  output  12  remainder BCD, remainder[7:0] converted.
- busy  output  1  conversion in progress.
- bcdValid  output  1  qBcd/rBcd hold a completed conversion.
- errFlag  output  1  last captured remainder had bit 8 set.
- overrun  output  1  sticky: a divEnd rise arrived while busy.

## Operation
- divEnd is registered as divEnd_d. Start condition at an edge: divEnd=1 and divEnd_d=0. A level held high starts exactly one conversion.
- FSM states and transitions:
  - IDLE: on start, go to CONV.
  - CONV: runs 8 iterations, then goes to DONE.
  - DONE: goes to IDLE next cycle.
  - In DONE and IDLE, a start goes to CONV directly. DONE never blocks a start.
- Capture (start edge in IDLE/DONE):
  - Load binQ←quotient, binR←remainder[7:0], BCD work registers←0.
  - errFlag←remainder[8].
  - iteration counter←0.
  - bcdValid←0.
- Each CONV cycle, applied to both channels in parallel:
  - Every BCD digit ≥5 gets +3.
  - Then {bcd,bin} shifts left by 1.
  - Counter increments.
- On the 8th iteration edge, the final BCD values (post-iteration) are written to qBcd/rBcd, bcdValid←1, and state goes to DONE.
- qBcd/rBcd keep the previous result during CONV. They change only on the completion edge.
- errFlag=1 does not suppress conversion. Both fields still convert the low 8 bits; consumers gate on errFlag.
- Start while in CONV: ignored, conversion continues, overrun←1. overrun clears only on reset.
- Arithmetic: 8-bit input ≤255, so 12 bits suffice. Hundreds digit ≤2; no overflow possible.
- Reset values: all outputs 0, state IDLE, divEnd_d 0, counter 0.

## Timing
- Edge E0 sees the start: capture, busy=1 after E0.
- Iterations happen on E1..E8.
- After E8: busy=0, bcdValid=1, outputs valid. Latency is 8 cycles from the capture edge.
- Earliest next capture is E9, if divEnd has fallen and risen again. divEnd must be low for at least one edge between conversions.
- Reset mid-CONV: immediate return to IDLE with all outputs 0. A divEnd still high at reset release is not a start unless divEnd_d sampled 0 first. divEnd_d resets to 0, so a held-high divEnd does start one conversion after release. This is the required behaviour.
- busy and bcdValid are never simultaneously 1.

## Structure
- Shared package div_pkg:
  - state enum IDLE/CONV/DONE.
  - ITER=8.
  - BCD_W=12.
  - digit constants ADD3_TH=5, ADD3_K=3.
- One combinational sub-module, dabble_step: 8-bit bin + 12-bit bcd in, shifted-and-adjusted pair out. Instantiated twice (quotient, remainder).
- FSM, counter and edge detect live in div_bcd_conv.

## Test plan
- Quotient 28, remainder 9'd4, divEnd pulse -> at E8: qBcd=12'h028, rBcd=12'h004, bcdValid=1, busy=0, errFlag=0.
- Quotient 255, remainder 0 -> qBcd=12'h255, rBcd=12'h000. Then quotient 100, remainder 9'd99 -> during CONV qBcd stays 12'h255; after E8 qBcd=12'h100, rBcd=12'h099.
- Remainder 9'h1F3, quotient 5 -> errFlag=1, qBcd=12'h005, rBcd=12'h243.
- divEnd held high 20 cycles -> exactly one conversion (busy high 8 cycles), overrun=0.
- divEnd falls and rises again at E3 of a conversion -> conversion completes with the original operands, overrun=1 and stays 1 until rst.
- rst asserted at E4 of CONV with divEnd low -> all outputs 0 asynchronously, state IDLE, no bcdValid after release.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg: shared types and constants for the divider BCD result stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;
  localparam int ITER  = 8;
  localparam int BCD_W = 12;
  localparam logic [3:0] ADD3_TH = 4'd5;
  localparam logic [3:0] ADD3_K  = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/div_bcd_conv_if.sv
// ============================================================================
// div_bcd_conv_if: divider-result handshake and BCD readout bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface div_bcd_conv_if;
  import div_pkg::*;

  logic             divEnd;
  logic [7:0]       quotient;
  logic [8:0]       remainder;
  logic [BCD_W-1:0] qBcd;
  logic [BCD_W-1:0] rBcd;
  logic             busy;
  logic             bcdValid;
  logic             errFlag;
  logic             overrun;

  modport master (
    output divEnd, quotient, remainder,
    input  qBcd, rBcd, busy, bcdValid, errFlag, overrun
  );

  modport slave (
    input  divEnd, quotient, remainder,
    output qBcd, rBcd, busy, bcdValid, errFlag, overrun
  );
endinterface

`default_nettype wire

// File: rtl/div_bcd_conv_dabble_step.sv
// ============================================================================
// dabble_step: one double-dabble iteration (add-3 adjust, then shift left).
// Revision: 1.0
// ============================================================================
`default_nettype none

module dabble_step
  import div_pkg::*;
(
  input  logic [7:0]       bin_i,
  input  logic [BCD_W-1:0] bcd_i,
  output logic [7:0]       bin_o,
  output logic [BCD_W-1:0] bcd_o
);
  logic [BCD_W-1:0] w_adj;

  for (genvar d = 0; d < BCD_W / 4; d++) begin : g_digit
    assign w_adj[d*4 +: 4] = (bcd_i[d*4 +: 4] >= ADD3_TH) ?
                             bcd_i[d*4 +: 4] + ADD3_K : bcd_i[d*4 +: 4];
  end

  assign bcd_o = {w_adj[BCD_W-2:0], bin_i[7]};
  assign bin_o = {bin_i[6:0], 1'b0};
endmodule

`default_nettype wire

// File: rtl/div_bcd_conv.sv
// ============================================================================
// div_bcd_conv: captures divider quotient/remainder on divEnd rise and
// converts both to 3-digit packed BCD, one dabble iteration per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_bcd_conv
  import div_pkg::*;
#(
  parameter int ITER = div_pkg::ITER
) (
  input  wire logic         clk,
  input  wire logic         rst,
  div_bcd_conv_if.slave     bus
);
  state_t           state_q, state_d;
  logic             div_end_q;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       bin_q_q, bin_q_d, bin_r_q, bin_r_d;
  logic [BCD_W-1:0] bcd_q_q, bcd_q_d, bcd_r_q, bcd_r_d;
  logic [BCD_W-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic             err_q, err_d, valid_q, valid_d, over_q, over_d, busy_q, busy_d;

  logic             w_start;
  logic [7:0]       w_bin_q_nx, w_bin_r_nx;
  logic [BCD_W-1:0] w_bcd_q_nx, w_bcd_r_nx;

  assign w_start = bus.divEnd & ~div_end_q;

  dabble_step u_step_q (
    .bin_i (bin_q_q), .bcd_i (bcd_q_q),
    .bin_o (w_bin_q_nx), .bcd_o (w_bcd_q_nx)
  );

  dabble_step u_step_r (
    .bin_i (bin_r_q), .bcd_i (bcd_r_q),
    .bin_o (w_bin_r_nx), .bcd_o (w_bcd_r_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_q_d = bin_q_q;
    bin_r_d = bin_r_q;
    bcd_q_d = bcd_q_q;
    bcd_r_d = bcd_r_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    err_d   = err_q;
    valid_d = valid_q;
    over_d  = over_q;
    busy_d  = busy_q;
    case (state_q)
      CONV: begin
        bin_q_d = w_bin_q_nx;
        bin_r_d = w_bin_r_nx;
        bcd_q_d = w_bcd_q_nx;
        bcd_r_d = w_bcd_r_nx;
        cnt_d   = cnt_q + 4'd1;
        // A new divEnd rise mid-conversion is dropped and only flagged.
        if (w_start) over_d = 1'b1;
        if (cnt_q == 4'(ITER - 1)) begin
          q_out_d = w_bcd_q_nx;
          r_out_d = w_bcd_r_nx;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (w_start) begin
          bin_q_d = bus.quotient;
          bin_r_d = bus.remainder[7:0];
          bcd_q_d = '0;
          bcd_r_d = '0;
          err_d   = bus.remainder[8];
          cnt_d   = 4'd0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_end_q <= 1'b0;
      cnt_q     <= '0;
      bin_q_q   <= '0;
      bin_r_q   <= '0;
      bcd_q_q   <= '0;
      bcd_r_q   <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      over_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_end_q <= bus.divEnd;
      cnt_q     <= cnt_d;
      bin_q_q   <= bin_q_d;
      bin_r_q   <= bin_r_d;
      bcd_q_q   <= bcd_q_d;
      bcd_r_q   <= bcd_r_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      over_q    <= over_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.qBcd     = q_out_q;
  assign bus.rBcd     = r_out_q;
  assign bus.busy     = busy_q;
  assign bus.bcdValid = valid_q;
  assign bus.errFlag  = err_q;
  assign bus.overrun  = over_q;
endmodule

`default_nettype wire

// File: tb/tb_div_bcd_conv.sv
// ============================================================================
// tb_div_bcd_conv: scoreboard bench for div_bcd_conv with a decimal model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_bcd_conv;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic        err;
  } exp_t;

  exp_t sb[$];

  div_bcd_conv_if bus ();

  div_bcd_conv #(.ITER(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int x);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rising bcdValid.
  logic prev_valid;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.busy && bus.bcdValid) chk("busy_valid_exclusive", 1, 0);
      if (bus.bcdValid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("qBcd", 32'(bus.qBcd), 32'(e.q));
          chk("rBcd", 32'(bus.rBcd), 32'(e.r));
          chk("errFlag", 32'(bus.errFlag), 32'(e.err));
        end
      end
      prev_valid = bus.bcdValid;
    end
  end

  function automatic exp_t model(input int q, input int r);
    exp_t e;
    e.q   = to_bcd(q);
    e.r   = to_bcd(r % 256);
    e.err = (r >= 256);
    return e;
  endfunction

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic conv(input int q, input int r);
    @(negedge clk);
    bus.quotient  = 8'(q);
    bus.remainder = 9'(r);
    bus.divEnd    = 1'b1;
    sb.push_back(model(q, r));
    @(negedge clk);
    bus.divEnd = 1'b0;
    chk("busy_after_capture", 32'(bus.busy), 1);
    chk("valid_cleared_on_capture", 32'(bus.bcdValid), 0);
    wait_idle("conv");
  endtask

  int busy_cnt;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.divEnd = 1'b0;
    bus.quotient = '0;
    bus.remainder = '0;
    repeat (3) @(negedge clk);
    chk("rst_qBcd", 32'(bus.qBcd), 0);
    chk("rst_rBcd", 32'(bus.rBcd), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.bcdValid), 0);
    chk("rst_err", 32'(bus.errFlag), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    rst = 1'b1;
    @(negedge clk);

    conv(28, 4);
    chk("valid_after_done", 32'(bus.bcdValid), 1);
    conv(255, 0);

    // Next conversion must keep the previous result visible while running.
    @(negedge clk);
    bus.quotient = 8'd100; bus.remainder = 9'd99; bus.divEnd = 1'b1;
    sb.push_back(model(100, 99));
    @(negedge clk);
    bus.divEnd = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_during_conv", 32'(bus.qBcd), 32'(to_bcd(255)));
    wait_idle("hold");

    conv(5, 9'h1F3);
    chk("err_sticky_until_next", 32'(bus.errFlag), 1);

    for (int i = 0; i < 20; i++) conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)));

    // Held-high divEnd yields exactly one conversion.
    @(negedge clk);
    bus.quotient = 8'd73; bus.remainder = 9'd200; bus.divEnd = 1'b1;
    sb.push_back(model(73, 200));
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    bus.divEnd = 1'b0;
    chk("held_busy_cycles", 32'(busy_cnt), 8);
    chk("held_no_overrun", 32'(bus.overrun), 0);

    // Second rise during CONV: original operands kept, overrun latched.
    @(negedge clk);
    bus.quotient = 8'd199; bus.remainder = 9'd58; bus.divEnd = 1'b1;
    sb.push_back(model(199, 58));
    @(negedge clk);
    bus.divEnd = 1'b0;
    @(negedge clk);
    bus.quotient = 8'd11; bus.remainder = 9'd22; bus.divEnd = 1'b1;
    @(negedge clk);
    bus.divEnd = 1'b0;
    wait_idle("overrun");
    chk("overrun_set", 32'(bus.overrun), 1);
    conv(64, 128);
    chk("overrun_sticky", 32'(bus.overrun), 1);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    bus.quotient = 8'd150; bus.remainder = 9'd77; bus.divEnd = 1'b1;
    @(negedge clk);
    bus.divEnd = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_qBcd", 32'(bus.qBcd), 0);
    chk("async_rst_rBcd", 32'(bus.rBcd), 0);
    chk("async_rst_overrun", 32'(bus.overrun), 0);
    chk("async_rst_err", 32'(bus.errFlag), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_no_valid", 32'(bus.bcdValid), 0);
    chk("post_rst_idle", 32'(bus.busy), 0);

    conv(0, 1);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
